ifu_miss_fill: RTL and testbench

IFU_MISS_FILL -- requirements
Module: ifu_miss_fill

---
 rtl/ifu_miss_fill.sv | 162 ++++++++++++++++
 tb/tb_ifu_miss_fill.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_miss_fill.sv
// Instruction-fetch miss/fill sequencer.
// When a fetch lookup misses, this block picks a victim way and requests the
// line from memory. It then writes the returned line into the tag/data arrays
// and keeps the per-way valid bits.

package ifu_pkg;
    localparam int IFU_WAYS_NUM = 16;
endpackage

module ifu_miss_fill #(
    parameter int WAYS_NUM   = ifu_pkg::IFU_WAYS_NUM,
    parameter int TAG_WIDTH  = 26,
    parameter int LINE_WIDTH = 128,
    parameter int WAY_W      = $clog2(WAYS_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [TAG_WIDTH-1:0]  lookup_tag,
    input  logic                  lookup_hit,
    input  logic                  flush,
    output logic                  cache_miss,
    output logic                  cache_full,
    input  logic [WAY_W-1:0]      evicted_cl,
    output logic [WAYS_NUM-1:0]   valid_vec,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [TAG_WIDTH-1:0]  mem_req_tag,
    input  logic                  mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data,
    output logic                  fill_we,
    output logic [WAY_W-1:0]      fill_way,
    output logic [TAG_WIDTH-1:0]  fill_tag,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic                  fill_busy,
    output logic [15:0]           miss_count
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } state_t;

    state_t                state;
    logic                  busy_q;
    logic                  req_valid_q;
    logic                  fill_we_q;
    logic                  flush_pending;
    logic [WAYS_NUM-1:0]   valid_q;
    logic [WAY_W-1:0]      lat_way;
    logic [TAG_WIDTH-1:0]  lat_tag;
    logic [LINE_WIDTH-1:0] lat_data;
    logic [15:0]           miss_count_q;

    logic                  miss_accept;
    logic [WAY_W-1:0]      free_way;
    logic [WAY_W-1:0]      victim_way;

    // A miss is taken only while idle and not flushing. Gating with reset keeps the pulse low during reset.
    assign miss_accept = rst && (state == IDLE) && lookup_valid && !lookup_hit && !flush;

    assign cache_miss    = miss_accept;
    assign cache_full    = &valid_q;
    assign valid_vec     = valid_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_tag   = lat_tag;
    assign fill_we       = fill_we_q;
    assign fill_way      = lat_way;
    assign fill_tag      = lat_tag;
    assign fill_data     = lat_data;
    assign fill_busy     = busy_q;
    assign miss_count    = miss_count_q;

    // Priority-encode the lowest-index invalid way as the victim for a cache that is not full.
    always_comb begin
        free_way = '0;
        for (int i = WAYS_NUM - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_way = WAY_W'(i);
            end
        end
    end

    assign victim_way = cache_full ? evicted_cl : free_way;

    // Miss sequencer: latch the miss, request the line, capture the response, then write it for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            busy_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            fill_we_q     <= 1'b0;
            flush_pending <= 1'b0;
            valid_q       <= '0;
            lat_way       <= '0;
            lat_tag       <= '0;
            lat_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (miss_accept) begin
                        lat_tag     <= lookup_tag;
                        lat_way     <= victim_way;
                        state       <= REQ;
                        busy_q      <= 1'b1;
                        req_valid_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        state       <= WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (mem_rsp_valid) begin
                        lat_data  <= mem_rsp_data;
                        state     <= FILL;
                        fill_we_q <= 1'b1;
                    end
                end
                FILL: begin
                    state         <= IDLE;
                    busy_q        <= 1'b0;
                    fill_we_q     <= 1'b0;
                    flush_pending <= 1'b0;
                    if (flush_pending || flush) begin
                        valid_q <= '0;
                    end else begin
                        valid_q[lat_way] <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy_q      <= 1'b0;
                    req_valid_q <= 1'b0;
                    fill_we_q   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating miss counter. A flush leaves it untouched; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_count_q <= '0;
        end else if (miss_accept && (miss_count_q != 16'hFFFF)) begin
            miss_count_q <= miss_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_ifu_miss_fill.sv
// Testbench for ifu_miss_fill. It keeps a queue of expected fill writes and
// models the valid bits and the miss count.

module tb_ifu_miss_fill;

    localparam int WAYS_NUM   = 16;
    localparam int TAG_WIDTH  = 26;
    localparam int LINE_WIDTH = 128;
    localparam int WAY_W      = 4;

    typedef struct packed {
        logic [WAY_W-1:0]      way;
        logic [TAG_WIDTH-1:0]  tag;
        logic [LINE_WIDTH-1:0] data;
    } fill_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  lookup_valid;
    logic [TAG_WIDTH-1:0]  lookup_tag;
    logic                  lookup_hit;
    logic                  flush;
    logic                  cache_miss;
    logic                  cache_full;
    logic [WAY_W-1:0]      evicted_cl;
    logic [WAYS_NUM-1:0]   valid_vec;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [TAG_WIDTH-1:0]  mem_req_tag;
    logic                  mem_rsp_valid;
    logic [LINE_WIDTH-1:0] mem_rsp_data;
    logic                  fill_we;
    logic [WAY_W-1:0]      fill_way;
    logic [TAG_WIDTH-1:0]  fill_tag;
    logic [LINE_WIDTH-1:0] fill_data;
    logic                  fill_busy;
    logic [15:0]           miss_count;

    int                    tests_run = 0;
    int                    tests_failed = 0;
    int                    fill_seen = 0;
    fill_t                 sb_queue[$];
    fill_t                 sb_exp;
    logic [WAYS_NUM-1:0]   exp_valid;
    logic [15:0]           exp_count;

    ifu_miss_fill #(
        .WAYS_NUM  (WAYS_NUM),
        .TAG_WIDTH (TAG_WIDTH),
        .LINE_WIDTH(LINE_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_tag   (lookup_tag),
        .lookup_hit   (lookup_hit),
        .flush        (flush),
        .cache_miss   (cache_miss),
        .cache_full   (cache_full),
        .evicted_cl   (evicted_cl),
        .valid_vec    (valid_vec),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_tag  (mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .fill_we      (fill_we),
        .fill_way     (fill_way),
        .fill_tag     (fill_tag),
        .fill_data    (fill_data),
        .fill_busy    (fill_busy),
        .miss_count   (miss_count)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [LINE_WIDTH-1:0] observed,
                               input logic [LINE_WIDTH-1:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", name, observed, expected, $time);
        end
    endtask

    // Each fill write must match the oldest outstanding expected fill.
    always @(negedge clk) begin
        if (rst === 1'b1 && fill_we === 1'b1) begin
            fill_seen++;
            if (sb_queue.size() == 0) begin
                checkOutput("fill_unexpected", 1, 0);
            end else begin
                sb_exp = sb_queue.pop_front();
                checkOutput("fill_way", fill_way, sb_exp.way);
                checkOutput("fill_tag", fill_tag, sb_exp.tag);
                checkOutput("fill_data", fill_data, sb_exp.data);
            end
        end
    end

    // Stop the run with a failure if the stimulus never reaches the summary line.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Runs one complete miss. A negative flush_cycle means no flush is driven.
    task automatic applyStimulus(input logic [TAG_WIDTH-1:0] tag, input logic [WAY_W-1:0] evict,
                                 input int ready_delay, input int rsp_delay, input bit stray_rsp,
                                 input bit busy_lookup, input int flush_cycle);
        logic [LINE_WIDTH-1:0] data;
        logic [WAY_W-1:0]      exp_way;
        int                    fills_before;
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        fills_before = fill_seen;
        exp_way = evict;
        if (!(&exp_valid)) begin
            for (int i = WAYS_NUM - 1; i >= 0; i--) begin
                if (!exp_valid[i]) exp_way = WAY_W'(i);
            end
        end

        @(posedge clk); #1;
        lookup_valid = 1'b1;
        lookup_hit   = 1'b0;
        lookup_tag   = tag;
        evicted_cl   = evict;
        #2;
        checkOutput("cache_miss_accept", cache_miss, 1);
        sb_queue.push_back('{way: exp_way, tag: tag, data: data});

        @(posedge clk); #1;
        checkOutput("cache_miss_busy", cache_miss, 0);
        checkOutput("req_valid", mem_req_valid, 1);
        checkOutput("req_tag", mem_req_tag, tag);
        checkOutput("busy_req", fill_busy, 1);
        lookup_valid = 1'b0;
        evicted_cl   = ~evict;

        for (int j = 0; j < ready_delay; j++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = stray_rsp && (j == 1);
            mem_rsp_data  = ~data;
            #2;
            checkOutput("req_valid_held", mem_req_valid, 1);
            checkOutput("req_tag_held", mem_req_tag, tag);
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        checkOutput("req_valid_drop", mem_req_valid, 0);

        for (int j = 0; j < rsp_delay; j++) begin
            flush         = (j == flush_cycle);
            lookup_valid  = busy_lookup;
            lookup_tag    = ~tag;
            mem_rsp_valid = (j == rsp_delay - 1);
            mem_rsp_data  = data;
            #2;
            if (busy_lookup) checkOutput("cache_miss_in_wait", cache_miss, 0);
            @(posedge clk); #1;
        end
        flush         = 1'b0;
        lookup_valid  = 1'b0;
        mem_rsp_valid = 1'b0;

        @(posedge clk); #1;
        checkOutput("busy_done", fill_busy, 0);
        checkOutput("fill_we_single", fill_seen, fills_before + 1);
        checkOutput("fill_way_hold", fill_way, exp_way);
        checkOutput("fill_tag_hold", fill_tag, tag);

        if (flush_cycle >= 0) exp_valid = '0;
        else exp_valid[exp_way] = 1'b1;
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        checkOutput("valid_vec", valid_vec, exp_valid);
        checkOutput("cache_full", cache_full, &exp_valid);
        checkOutput("miss_count", miss_count, exp_count);
    endtask

    // Main sequence.
    initial begin
        rst           = 1'b0;
        lookup_valid  = 1'b1;
        lookup_hit    = 1'b0;
        lookup_tag    = 26'h1234567;
        flush         = 1'b0;
        evicted_cl    = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        exp_valid     = '0;
        exp_count     = '0;

        // Reset state, with a miss-looking lookup held to show that cache_miss stays low.
        repeat (2) @(posedge clk);
        #3;
        checkOutput("rst_cache_miss", cache_miss, 0);
        checkOutput("rst_cache_full", cache_full, 0);
        checkOutput("rst_req_valid", mem_req_valid, 0);
        checkOutput("rst_fill_we", fill_we, 0);
        checkOutput("rst_busy", fill_busy, 0);
        checkOutput("rst_fill_way", fill_way, 0);
        checkOutput("rst_fill_tag", fill_tag, 0);
        checkOutput("rst_fill_data", fill_data, 0);
        checkOutput("rst_req_tag", mem_req_tag, 0);
        checkOutput("rst_miss_count", miss_count, 0);
        checkOutput("rst_valid_vec", valid_vec, 0);
        lookup_valid  = 1'b0;
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Cold miss.
        applyStimulus(26'h0ABCDEF, 4'd0, 0, 1, 1'b0, 1'b0, -1);

        // Fill the remaining ways. One miss sees backpressure and a stray response; another sees a lookup while busy.
        for (int i = 1; i < WAYS_NUM; i++) begin
            applyStimulus(26'h100000 + 26'(i), 4'd0,
                          (i == 3) ? 5 : (i % 2), 1 + (i % 3),
                          (i == 3), (i == 6), -1);
        end
        checkOutput("full_after_16", cache_full, 1);

        // A miss on a full cache replaces the way chosen by the replacement policy.
        applyStimulus(26'h2AAAAAA, 4'd9, 0, 1, 1'b0, 1'b0, -1);
        checkOutput("valid_full_kept", valid_vec, 16'hFFFF);

        // A flush while waiting for the response: the fill still happens, and every line is then invalid.
        applyStimulus(26'h3555555, 4'd5, 1, 3, 1'b0, 1'b0, 0);

        // Victim selection restarts at way 0.
        applyStimulus(26'h0000777, 4'd3, 0, 2, 1'b0, 1'b0, -1);

        // Simultaneous flush and miss in idle.
        @(posedge clk); #1;
        lookup_valid = 1'b1;
        lookup_hit   = 1'b0;
        lookup_tag   = 26'h0111111;
        flush        = 1'b1;
        #2;
        checkOutput("flush_miss_pulse", cache_miss, 0);
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        flush        = 1'b0;
        exp_valid    = '0;
        checkOutput("flush_miss_idle", fill_busy, 0);
        checkOutput("flush_miss_valid", valid_vec, exp_valid);
        checkOutput("flush_miss_count", miss_count, exp_count);

        // A lookup that hits is not a miss.
        @(posedge clk); #1;
        lookup_valid = 1'b1;
        lookup_hit   = 1'b1;
        #2;
        checkOutput("hit_no_miss", cache_miss, 0);
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        lookup_hit   = 1'b0;
        checkOutput("hit_idle", fill_busy, 0);
        checkOutput("hit_count", miss_count, exp_count);

        // Reset asserted while waiting: the response that follows must not produce a fill.
        begin
            int fills_before;
            fills_before = fill_seen;
            @(posedge clk); #1;
            lookup_valid = 1'b1;
            lookup_tag   = 26'h0222222;
            @(posedge clk); #1;
            lookup_valid  = 1'b0;
            mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            checkOutput("rstwait_busy", fill_busy, 1);
            #1;
            rst = 1'b0;
            #1;
            checkOutput("rstwait_busy_low", fill_busy, 0);
            checkOutput("rstwait_count", miss_count, 0);
            checkOutput("rstwait_req_tag", mem_req_tag, 0);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = {4{32'hDEADBEEF}};
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            @(posedge clk); #1;
            checkOutput("rstwait_no_fill", fill_seen, fills_before);
            checkOutput("rstwait_idle", fill_busy, 0);
            checkOutput("rstwait_valid", valid_vec, 0);
            checkOutput("rstwait_count_after", miss_count, 0);
            exp_valid = '0;
            exp_count = '0;
        end

        // The block is usable again after the abandoned miss.
        applyStimulus(26'h0333333, 4'd7, 0, 1, 1'b0, 1'b0, -1);

        checkOutput("scoreboard_drained", sb_queue.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
